// File: rtl/datamem_vec_responder.sv
// Multi-cycle data-memory responder: one scalar or vector load/store per request,
// processed one 32-bit RAM word per cycle, answered through a valid/ready response.
module datamem_vec_responder #(
    parameter int unsigned VLEN   = 128,
    parameter int unsigned ADDR_W = 8
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     addr,
    input  logic [VLEN-1:0] wdata,
    input  logic [3:0]      wmem,
    input  logic            vector,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [VLEN-1:0] rdata,
    output logic            busy
);

    localparam int unsigned BEATS = VLEN / 32;
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEAT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [VLEN-1:0]     wdata_q, wdata_d;
    logic [3:0]          wmem_q, wmem_d;
    logic                vector_q, vector_d;
    logic [VLEN-1:0]     rdata_q, rdata_d;

    logic [31:0]         mem [DEPTH];
    logic [ADDR_W-1:0]   idx;
    logic [31:0]         wr_word;
    logic                mem_we;
    logic                last_beat;
    logic                addr_unused;

    // Byte offset and bits above the RAM range do not select a word.
    assign addr_unused = ^{addr[31:ADDR_W+2], addr[1:0]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        wdata_d   = wdata_q;
        wmem_d    = wmem_q;
        vector_d  = vector_q;
        rdata_d   = rdata_q;
        mem_we    = 1'b0;
        idx       = base_q + ADDR_W'(cnt_q);
        wr_word   = wdata_q[32*int'(cnt_q) +: 32];
        last_beat = !vector_q || (cnt_q == CNT_W'(BEATS - 1));

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    base_d   = addr[ADDR_W+1:2];
                    wdata_d  = wdata;
                    wmem_d   = wmem;
                    vector_d = vector;
                    cnt_d    = '0;
                    rdata_d  = '0;
                    state_d  = BEAT;
                end
            end
            BEAT: begin
                if (wmem_q != 4'b0000) begin
                    mem_we = 1'b1;
                end else begin
                    rdata_d[32*int'(cnt_q) +: 32] = mem[idx];
                end
                if (last_beat) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            base_q   <= '0;
            wdata_q  <= '0;
            wmem_q   <= '0;
            vector_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            base_q   <= base_d;
            wdata_q  <= wdata_d;
            wmem_q   <= wmem_d;
            vector_q <= vector_d;
            rdata_q  <= rdata_d;
        end
    end

    // RAM is not reset; writes stop at once because reset forces IDLE.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wmem_q[i]) begin
                    mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rdata     = rdata_q;

endmodule
